// File: rtl/dff_bank_shadow_we.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_shadow_we
// Brief    : Shadow-staged register bank with set/clear/toggle writes and an
//            atomic commit of every shadow channel to the active outputs.
// Revision : 1.0
// ============================================================================
module dff_bank_shadow_we #(
  parameter int              WIDTH    = 8,
  parameter int              NUM_CH   = 4,
  parameter int              ADDR_W   = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [1:0]              wmode,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    commit,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [WIDTH-1:0]        rdata,
  output logic [WIDTH*NUM_CH-1:0] q,
  output logic [NUM_CH-1:0]       changed,
  output logic                    pending,
  output logic                    wr_err
);

  localparam logic [ADDR_W:0] c_NUM_CH = (ADDR_W+1)'(NUM_CH);

  localparam logic [1:0] c_MODE_WR  = 2'b00;
  localparam logic [1:0] c_MODE_SET = 2'b01;
  localparam logic [1:0] c_MODE_CLR = 2'b10;

  // Only a clean 1 counts; X/Z on the strobes must not cause a write or commit.
  logic w_we;
  logic w_commit;
  logic w_addr_ok;
  logic w_rd_ok;
  assign w_we      = (we === 1'b1);
  assign w_commit  = (commit === 1'b1);
  assign w_addr_ok = ({1'b0, waddr} < c_NUM_CH);
  assign w_rd_ok   = ({1'b0, raddr} < c_NUM_CH);

  logic [WIDTH*NUM_CH-1:0] w_sh_flat;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(gi);

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_act;
    logic             r_chg;
    logic [WIDTH-1:0] w_sh_nxt;
    logic             w_hit;

    assign w_hit = w_we && w_addr_ok && (waddr == c_IDX);

    always_comb begin
      w_sh_nxt = r_sh;
      if (w_hit) begin
        case (wmode)
          c_MODE_WR:  w_sh_nxt = wdata;
          c_MODE_SET: w_sh_nxt = r_sh | wdata;
          c_MODE_CLR: w_sh_nxt = r_sh & ~wdata;
          default:    w_sh_nxt = r_sh ^ wdata;
        endcase
      end
    end

    // Commit takes the post-write value so a same-cycle write is included.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sh  <= INIT_VAL;
        r_act <= INIT_VAL;
        r_chg <= 1'b0;
      end else begin
        r_sh  <= w_sh_nxt;
        r_chg <= 1'b0;
        if (w_commit) begin
          r_act <= w_sh_nxt;
          r_chg <= (w_sh_nxt != r_act);
        end
      end
    end

    assign w_sh_flat[gi*WIDTH +: WIDTH] = r_sh;
    assign q[gi*WIDTH +: WIDTH]         = r_act;
    assign changed[gi]                  = r_chg;
  end

  logic [WIDTH-1:0] w_rd;
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_rd_ok && (raddr == ADDR_W'(i))) begin
        w_rd = w_sh_flat[i*WIDTH +: WIDTH];
      end
    end
  end

  logic [WIDTH-1:0] r_rdata;
  logic             r_pending;
  logic             r_wr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata   <= '0;
      r_pending <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_rdata  <= w_rd;
      r_wr_err <= w_we && !w_addr_ok;
      if (w_commit) begin
        r_pending <= 1'b0;
      end else if (w_we && w_addr_ok) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign rdata   = r_rdata;
  assign pending = r_pending;
  assign wr_err  = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_shadow_we.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_bank_shadow_we
// Brief    : Directed bench for dff_bank_shadow_we (3 channels of 8 bits) with a
//            bank-level reference model compared every cycle.
// Revision : 1.0
// ============================================================================
module tb_dff_bank_shadow_we;

  localparam int         c_W    = 8;
  localparam int         c_N    = 3;
  localparam int         c_AW   = 2;
  localparam logic [7:0] c_INIT = 8'h5A;

  logic              clk = 1'b0;
  logic              rst, we, commit;
  logic [c_AW-1:0]   waddr, raddr;
  logic [1:0]        wmode;
  logic [c_W-1:0]    wdata;
  logic [c_W-1:0]    rdata;
  logic [c_W*c_N-1:0] q;
  logic [c_N-1:0]    changed;
  logic              pending, wr_err;

  int n_pass  = 0;
  int n_total = 0;

  dff_bank_shadow_we #(
    .WIDTH(c_W), .NUM_CH(c_N), .ADDR_W(c_AW), .INIT_VAL(c_INIT)
  ) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wmode(wmode), .wdata(wdata),
    .commit(commit), .raddr(raddr), .rdata(rdata), .q(q), .changed(changed),
    .pending(pending), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the bank as plain arrays, advanced once per rising edge.
  logic [7:0] m_sh  [c_N];
  logic [7:0] m_act [c_N];
  logic [7:0] m_rdata;
  logic [2:0] m_chg;
  logic       m_pend, m_err;
  bit         m_valid = 0;

  always @(posedge clk) begin
    logic [7:0] nxt [c_N];
    logic       wrote;
    if (rst === 1'b1) begin
      foreach (m_sh[i]) begin m_sh[i] = c_INIT; m_act[i] = c_INIT; end
      m_rdata = 0; m_chg = 0; m_pend = 0; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      nxt     = m_sh;
      wrote   = 0;
      m_rdata = (int'(raddr) < c_N) ? m_sh[raddr] : 8'h00;
      m_err   = (we === 1'b1) && (int'(waddr) >= c_N);
      if ((we === 1'b1) && (int'(waddr) < c_N)) begin
        wrote = 1;
        case (wmode)
          2'd0: nxt[waddr] = wdata;
          2'd1: nxt[waddr] = m_sh[waddr] | wdata;
          2'd2: nxt[waddr] = m_sh[waddr] & ~wdata;
          default: nxt[waddr] = m_sh[waddr] ^ wdata;
        endcase
      end
      m_chg = 0;
      if (commit === 1'b1) begin
        for (int i = 0; i < c_N; i++) m_chg[i] = (nxt[i] != m_act[i]);
        m_act  = nxt;
        m_pend = 0;
      end else if (wrote) begin
        m_pend = 1;
      end
      m_sh = nxt;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("q",       32'(q),       32'({m_act[2], m_act[1], m_act[0]}));
      check("changed", 32'(changed), 32'(m_chg));
      check("pending", 32'(pending), 32'(m_pend));
      check("wr_err",  32'(wr_err),  32'(m_err));
      check("rdata",   32'(rdata),   32'(m_rdata));
    end
  end

  task automatic step(input logic r, input logic w, input logic c, input logic [1:0] a,
                      input logic [1:0] m, input logic [7:0] d, input logic [1:0] ra);
    rst = r; we = w; commit = c; waddr = a; wmode = m; wdata = d; raddr = ra;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [1:0] ra);
    step(0, 0, 0, 2'd0, 2'd0, 8'h00, ra);
  endtask

  initial begin
    // Reset must win over a simultaneous write and commit.
    step(1, 1, 1, 2'd0, 2'd0, 8'hFF, 2'd0);
    check("lit_rst_q", 32'(q), 32'h005A5A5A);
    check("lit_rst_pend", 32'(pending), 32'h0);
    check("lit_rst_chg", 32'(changed), 32'h0);
    idle(2'd0);

    // Staged write is invisible on q until commit.
    step(0, 1, 0, 2'd2, 2'd0, 8'hA5, 2'd2);
    check("lit_ch2_before_commit", 32'(q[23:16]), 32'h5A);
    check("lit_pend_after_write", 32'(pending), 32'h1);
    idle(2'd2);
    check("lit_rdata_ch2", 32'(rdata), 32'hA5);
    step(0, 0, 1, 2'd0, 2'd0, 8'h00, 2'd2);
    check("lit_ch2_commit", 32'(q[23:16]), 32'hA5);
    check("lit_chg_ch2", 32'(changed), 32'h4);
    idle(2'd0);
    check("lit_chg_clear", 32'(changed), 32'h0);

    // Read-modify-write modes on ch1.
    step(0, 1, 0, 2'd1, 2'd0, 8'hF0, 2'd1);
    step(0, 1, 0, 2'd1, 2'd1, 8'h0F, 2'd1);
    step(0, 1, 0, 2'd1, 2'd2, 8'h81, 2'd1);
    check("lit_rdata_set", 32'(rdata), 32'hFF);
    step(0, 1, 0, 2'd1, 2'd3, 8'hFF, 2'd1);
    check("lit_rdata_clr", 32'(rdata), 32'h7E);
    step(0, 0, 1, 2'd0, 2'd0, 8'h00, 2'd1);
    check("lit_ch1_commit", 32'(q[15:8]), 32'h81);
    check("lit_rdata_tgl", 32'(rdata), 32'h81);

    // Write and commit in the same cycle.
    step(0, 1, 1, 2'd0, 2'd0, 8'h3C, 2'd0);
    check("lit_ch0_wc", 32'(q[7:0]), 32'h3C);
    check("lit_pend_wc", 32'(pending), 32'h0);
    check("lit_chg_wc", 32'(changed), 32'h1);

    // Invalid channel: only wr_err pulses, pending from earlier write holds.
    step(0, 1, 0, 2'd2, 2'd0, 8'hA5, 2'd3);
    step(0, 1, 0, 2'd3, 2'd0, 8'hFF, 2'd3);
    check("lit_wr_err", 32'(wr_err), 32'h1);
    check("lit_pend_held", 32'(pending), 32'h1);
    check("lit_q_held", 32'(q), 32'hA5813C);
    check("lit_rdata_oob", 32'(rdata), 32'h0);
    idle(2'd0);
    check("lit_wr_err_pulse", 32'(wr_err), 32'h0);

    // Commit of identical data reports no change.
    step(0, 0, 1, 2'd0, 2'd0, 8'h00, 2'd0);
    check("lit_chg_same", 32'(changed), 32'h0);
    step(0, 0, 1, 2'd0, 2'd0, 8'h00, 2'd0);
    step(0, 1'bx, 0, 2'd0, 2'd0, 8'h00, 2'd0);
    step(0, 0, 1'bx, 2'd0, 2'd0, 8'h00, 2'd0);
    idle(2'd0);

    // Reset mid-sequence discards staged data.
    step(0, 1, 0, 2'd1, 2'd0, 8'h11, 2'd1);
    step(1, 0, 0, 2'd0, 2'd0, 8'h00, 2'd1);
    idle(2'd1);
    check("lit_rdata_after_rst", 32'(rdata), 32'h5A);
    check("lit_q_after_rst", 32'(q), 32'h5A5A5A);

    // Mixed traffic against the model.
    for (int k = 0; k < 300; k++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           2'($urandom), 2'($urandom), 8'($urandom), 2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
